stepper_seq_ctrl: RTL and testbench

- Parametrised successor to the fixed-rate, full-step stepper rotator.
- Accepts move commands through a valid/ready handshake. Each command carries a step count, direction, full/half-step mode and a per-step period.
- Drives both H-bridge input pairs of one motor channel plus the standby line.
- Generates a VREF current-limit PWM with separate run and hold duties.
- Sits between the board-level control logic (UART/I2C command decoders) and the motor driver pins.

---
 rtl/stepper_seq_ctrl.sv | 165 ++++++++++++++++
 tb/tb_stepper_seq_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/stepper_seq_ctrl.sv
// rtl/stepper_seq_ctrl.sv - command-driven full/half-step stepper sequencer with VREF PWM
// Optional absolute position output: define STEPPER_POS_COUNTER_EN.
module stepper_seq_ctrl #(
  parameter int STEP_W   = 16,
  parameter int PERIOD_W = 24,
  parameter int PWM_W    = 3,
  parameter int POS_W    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [STEP_W-1:0]   cmd_steps,
  input  logic                cmd_dir,
  input  logic                cmd_half,
  input  logic [PERIOD_W-1:0] cmd_period,
  input  logic                abort,
  input  logic [PWM_W-1:0]    run_duty,
  input  logic [PWM_W-1:0]    hold_duty,
  output logic                ain1,
  output logic                ain2,
  output logic                bin1,
  output logic                bin2,
  output logic                stby,
  output logic                vref,
  output logic                busy,
  output logic                done,
  output logic [STEP_W-1:0]   remaining
`ifdef STEPPER_POS_COUNTER_EN
  ,
  output logic signed [POS_W-1:0] position
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state, state_nxt;
  logic [2:0]          pos, pos_nxt;
  logic                dir_q, half_q;
  logic [PERIOD_W-1:0] period_q, timer;
  logic [PWM_W-1:0]    pwm_cnt, duty;
  logic [3:0]          coil_nxt;
  logic                accept, step_due;

  assign cmd_ready = stby & (state == IDLE);
  assign busy      = (state == RUN);
  assign accept    = cmd_valid & cmd_ready;
  // abort wins over a step that falls due on the same cycle
  assign step_due  = (state == RUN) & ~abort & (timer == period_q - PERIOD_W'(1));
  assign duty      = (state == RUN) ? run_duty : hold_duty;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (cmd_steps == '0) ? DONE : RUN;
      RUN: begin
        if (abort)                                    state_nxt = DONE;
        else if (step_due && remaining == STEP_W'(1)) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // next phase index; full-step snaps an odd index onto the adjacent even one
  always_comb begin
    pos_nxt = pos;
    if (half_q) pos_nxt = dir_q ? 3'(pos + 3'd1) : 3'(pos - 3'd1);
    else if (dir_q) pos_nxt = 3'((pos | 3'd1) + 3'd1);
    else            pos_nxt = 3'(((pos + 3'd1) & 3'b110) - 3'd2);
  end

  // command latch, step timer, phase index and step countdown
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_q     <= 1'b0;
      half_q    <= 1'b0;
      period_q  <= PERIOD_W'(1);
      timer     <= '0;
      pos       <= 3'd0;
      remaining <= '0;
    end else if (accept) begin
      dir_q     <= cmd_dir;
      half_q    <= cmd_half;
      period_q  <= (cmd_period == '0) ? PERIOD_W'(1) : cmd_period;
      timer     <= '0;
      remaining <= cmd_steps;
    end else if (state == RUN) begin
      if (abort) begin
        timer     <= '0;
        remaining <= '0;
      end else if (step_due) begin
        timer     <= '0;
        pos       <= pos_nxt;
        remaining <= remaining - STEP_W'(1);
      end else begin
        timer <= timer + PERIOD_W'(1);
      end
    end
  end

`ifdef STEPPER_POS_COUNTER_EN
  logic signed [POS_W-1:0] pos_delta;

  // position moves in half-step units; a re-align step is only half a full step
  always_comb begin
    pos_delta = (half_q || pos[0]) ? POS_W'(1) : POS_W'(2);
    if (!dir_q) pos_delta = -pos_delta;
  end

  // absolute position accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        position <= '0;
    else if (step_due) position <= position + pos_delta;
  end
`endif

  // phase table as {ain1, ain2, bin1, bin2}
  always_comb begin
    coil_nxt = 4'b0000;
    case (pos)
      3'd0: coil_nxt = 4'b1010;
      3'd1: coil_nxt = 4'b0010;
      3'd2: coil_nxt = 4'b0110;
      3'd3: coil_nxt = 4'b0100;
      3'd4: coil_nxt = 4'b0101;
      3'd5: coil_nxt = 4'b0001;
      3'd6: coil_nxt = 4'b1001;
      3'd7: coil_nxt = 4'b1000;
      default: coil_nxt = 4'b0000;
    endcase
  end

  // registered coil drive, standby release and end-of-move pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {ain1, ain2, bin1, bin2} <= 4'b0000;
      stby <= 1'b0;
      done <= 1'b0;
    end else begin
      {ain1, ain2, bin1, bin2} <= coil_nxt;
      stby <= 1'b1;
      done <= (state == DONE);
    end
  end

  // free-running VREF PWM; duty 0 never asserts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
      vref    <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_W'(1);
      vref    <= (pwm_cnt < duty);
    end
  end

endmodule

// File: tb/tb_stepper_seq_ctrl.sv
// tb/tb_stepper_seq_ctrl.sv - self-checking bench for stepper_seq_ctrl
module tb_stepper_seq_ctrl;

  localparam int STEP_W = 16, PERIOD_W = 24, PWM_W = 3, POS_W = 32;

  logic clk = 1'b0;
  logic rst_n, cmd_valid, cmd_ready, cmd_dir, cmd_half, abort;
  logic [STEP_W-1:0] cmd_steps, remaining;
  logic [PERIOD_W-1:0] cmd_period;
  logic [PWM_W-1:0] run_duty, hold_duty;
  logic ain1, ain2, bin1, bin2, stby, vref, busy, done;
`ifdef STEPPER_POS_COUNTER_EN
  logic signed [POS_W-1:0] position;
`endif

  stepper_seq_ctrl #(.STEP_W(STEP_W), .PERIOD_W(PERIOD_W), .PWM_W(PWM_W), .POS_W(POS_W)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_steps(cmd_steps), .cmd_dir(cmd_dir), .cmd_half(cmd_half), .cmd_period(cmd_period),
    .abort(abort), .run_duty(run_duty), .hold_duty(hold_duty),
    .ain1(ain1), .ain2(ain2), .bin1(bin1), .bin2(bin2), .stby(stby), .vref(vref),
    .busy(busy), .done(done), .remaining(remaining)
`ifdef STEPPER_POS_COUNTER_EN
    , .position(position)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  int m_pos = 0;
  int m_position = 0;
  bit keep_valid = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // phase table from the datasheet view: A and B polarity per index
  function automatic logic [3:0] coils_for(input int p);
    int a, b;
    case (p)
      0: begin a = 1;  b = 1;  end
      1: begin a = 0;  b = 1;  end
      2: begin a = -1; b = 1;  end
      3: begin a = -1; b = 0;  end
      4: begin a = -1; b = -1; end
      5: begin a = 0;  b = -1; end
      6: begin a = 1;  b = -1; end
      default: begin a = 1; b = 0; end
    endcase
    return {a == 1, a == -1, b == 1, b == -1};
  endfunction

  // one step: half-step moves one slot; full-step jumps to the next even slot
  function automatic int nxt(input int p, input bit dir, input bit half);
    int d;
    if (half) d = 1;
    else      d = (p % 2 == 1) ? 1 : 2;
    return dir ? (p + d) % 8 : (p + 8 - d) % 8;
  endfunction

  function automatic int delta(input int p, input bit dir, input bit half);
    int d;
    d = (half || (p % 2 == 1)) ? 1 : 2;
    return dir ? d : -d;
  endfunction

  function automatic logic [3:0] coil_obs();
    return {ain1, ain2, bin1, bin2};
  endfunction

  task automatic send(input int steps, input bit dir, input bit half, input int period, input bit imm);
    int n = 0;
    cmd_steps  = STEP_W'(steps);
    cmd_dir    = dir;
    cmd_half   = half;
    cmd_period = PERIOD_W'(period);
    cmd_valid  = 1'b1;
    if (imm) check("ready_immediate", 32'(cmd_ready), 32'd1);
    while (!cmd_ready && n < 200) begin
      tick();
      n++;
    end
    if (!cmd_ready) check("ready_timeout", 32'(cmd_ready), 32'd1);
    tick();
    if (!keep_valid) cmd_valid = 1'b0;
  endtask

  task automatic run_move(input int steps, input bit dir, input bit half, input int period, input bit imm);
    int seq[0:64];
    int pd, last, idx, rem, sum;
    pd  = (period == 0) ? 1 : period;
    seq[0] = m_pos;
    sum = 0;
    for (int k = 1; k <= steps; k++) begin
      seq[k] = nxt(seq[k-1], dir, half);
      sum += delta(seq[k-1], dir, half);
    end
    send(steps, dir, half, period, imm);
    last = steps * pd + 1;
    for (int c = 0; c <= last; c++) begin
      if (c > 0) tick();
      idx = (c == 0) ? 0 : (c - 1) / pd;
      if (idx > steps) idx = steps;
      rem = steps - c / pd;
      if (rem < 0) rem = 0;
      check("coils",     32'(coil_obs()), 32'(coils_for(seq[idx])));
      check("remaining", 32'(remaining),  32'(rem));
      check("busy",      32'(busy),       32'(steps > 0 && c < steps * pd));
      check("done",      32'(done),       32'(c == last));
      check("cmd_ready", 32'(cmd_ready),  32'(c == last));
    end
    m_pos = seq[steps];
    m_position += sum;
`ifdef STEPPER_POS_COUNTER_EN
    check("position", 32'(position), 32'(m_position));
`endif
  endtask

  initial begin
    int h, p1, n;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_steps = '0; cmd_dir = 1'b0; cmd_half = 1'b0;
    cmd_period = '0; abort = 1'b0; run_duty = 3'd3; hold_duty = 3'd2;

    // reset state
    repeat (3) tick();
    check("rst_coils", 32'(coil_obs()), 32'd0);
    check("rst_stby",  32'(stby), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd0);
    check("rst_vref",  32'(vref), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_done",  32'(done), 32'd0);
    check("rst_rem",   32'(remaining), 32'd0);
    rst_n = 1'b1;
    tick();
    check("rel_coils", 32'(coil_obs()), 32'(coils_for(0)));
    check("rel_stby",  32'(stby), 32'd1);
    check("rel_ready", 32'(cmd_ready), 32'd1);

    // idle VREF duty over one full PWM period
    for (int d = 0; d < 8; d += 2) begin
      hold_duty = 3'(d);
      repeat (2) tick();
      h = 0;
      for (int i = 0; i < 8; i++) begin tick(); h += int'(vref); end
      check("vref_hold", 32'(h), 32'(d));
    end
    hold_duty = 3'd2;

    // directed moves
    run_move(4, 1'b1, 1'b0, 10, 1'b0);
    run_move(3, 1'b0, 1'b1, 0, 1'b0);
    run_move((5 - m_pos + 8) % 8, 1'b1, 1'b1, 1, 1'b0);
    run_move(2, 1'b1, 1'b0, 3, 1'b0);
    run_move(0, 1'b1, 1'b0, 5, 1'b0);

    // VREF run duty during a long step
    run_duty = 3'd5; hold_duty = 3'd1;
    send(1, 1'b1, 1'b1, 20, 1'b0);
    h = 0;
    for (int c = 1; c <= 21; c++) begin
      tick();
      if (c >= 2 && c <= 9) h += int'(vref);
      if (c == 21) check("run_done", 32'(done), 32'd1);
    end
    check("vref_run", 32'(h), 32'd5);
    m_position += delta(m_pos, 1'b1, 1'b1);
    m_pos = nxt(m_pos, 1'b1, 1'b1);
    run_duty = 3'd3; hold_duty = 3'd2;

    // command held valid across a move
    keep_valid = 1;
    run_move(2, 1'b1, 1'b1, 3, 1'b0);
    keep_valid = 0;
    run_move(2, 1'b1, 1'b1, 3, 1'b1);

    // abort on the cycle the second step falls due
    p1 = nxt(m_pos, 1'b1, 1'b0);
    send(5, 1'b1, 1'b0, 4, 1'b0);
    for (int c = 1; c <= 7; c++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_rem",   32'(remaining), 32'd0);
    check("abort_busy",  32'(busy), 32'd0);
    check("abort_ready", 32'(cmd_ready), 32'd0);
    tick();
    check("abort_done",  32'(done), 32'd1);
    check("abort_ready2",32'(cmd_ready), 32'd1);
    check("abort_coils", 32'(coil_obs()), 32'(coils_for(p1)));
    m_position += delta(m_pos, 1'b1, 1'b0);
    m_pos = p1;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_idle_ready", 32'(cmd_ready), 32'd1);

    // randomized moves
    for (int i = 0; i < 12; i++) begin
      run_move(int'($urandom_range(0, 10)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), int'($urandom_range(0, 4)), 1'b0);
      n = int'($urandom_range(0, 3));
      repeat (n) tick();
    end

    // reset mid-move
    send(6, 1'b0, 1'b1, 3, 1'b0);
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_coils", 32'(coil_obs()), 32'd0);
    check("mid_rst_stby",  32'(stby), 32'd0);
    check("mid_rst_busy",  32'(busy), 32'd0);
    check("mid_rst_rem",   32'(remaining), 32'd0);
    check("mid_rst_ready", 32'(cmd_ready), 32'd0);
    check("mid_rst_vref",  32'(vref), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("mid_rel_coils", 32'(coil_obs()), 32'(coils_for(0)));
    m_pos = 0;
    m_position = 0;
    run_move(3, 1'b1, 1'b0, 2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
